// File: rtl/inv_sub_bytes_ctrl.sv
// InvSubBytes sequencer: streams a 128-bit AES state through LANES shared
// Inv_Sbox lanes, one group of bytes per cycle, then presents the result with a done pulse.
module inv_sub_bytes_ctrl #(
    parameter int unsigned LANES = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [127:0]         state_in,
    output logic                 busy,
    output logic                 done,
    output logic [127:0]         state_out,
    output logic [8*LANES-1:0]   sbox_state,
    input  logic [8*LANES-1:0]   sbox_Sstate
);

    localparam int unsigned NB   = 16;
    localparam int unsigned NGRP = NB / LANES;
    localparam int unsigned GW   = (NGRP > 1) ? $clog2(NGRP) : 1;
    localparam int unsigned SW   = 128;

    generate
        if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
            $error("inv_sub_bytes_ctrl: LANES must be 1, 2, 4, 8 or 16");
        end
    endgenerate

    localparam logic [GW-1:0] GRP_LAST = GW'(NGRP - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } fsm_t;

    fsm_t            fsm_q, fsm_d;
    logic [GW-1:0]   grp_q, grp_d;
    logic [SW-1:0]   work_q, work_d;
    logic            busy_d;
    logic            done_d;
    logic [SW-1:0]   out_d;

    // Next-state, lane steering and result capture
    always_comb begin
        fsm_d      = fsm_q;
        grp_d      = grp_q;
        work_d     = work_q;
        busy_d     = 1'b0;
        done_d     = 1'b0;
        out_d      = state_out;
        sbox_state = '0;

        case (fsm_q)
            IDLE: begin
                if (start) begin
                    work_d = state_in;
                    grp_d  = '0;
                    fsm_d  = RUN;
                    busy_d = 1'b1;
                end
            end
            RUN: begin
                // byte i belongs to group i/LANES and rides lane i%LANES
                for (int i = 0; i < int'(NB); i++) begin
                    if (GW'(i / int'(LANES)) == grp_q) begin
                        sbox_state[8*(i % int'(LANES)) +: 8] = work_q[8*(int'(NB) - 1 - i) +: 8];
                        work_d[8*(int'(NB) - 1 - i) +: 8]    = sbox_Sstate[8*(i % int'(LANES)) +: 8];
                    end
                end
                if (grp_q == GRP_LAST) begin
                    fsm_d  = IDLE;
                    grp_d  = '0;
                    done_d = 1'b1;
                    out_d  = work_d;
                end else begin
                    grp_d  = grp_q + GW'(1);
                    busy_d = 1'b1;
                end
            end
            default: begin
                fsm_d = IDLE;
                grp_d = '0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q     <= IDLE;
            grp_q     <= '0;
            work_q    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            state_out <= '0;
        end else begin
            fsm_q     <= fsm_d;
            grp_q     <= grp_d;
            work_q    <= work_d;
            busy      <= busy_d;
            done      <= done_d;
            state_out <= out_d;
        end
    end

endmodule

// File: tb/tb_inv_sub_bytes_ctrl.sv
// Bench for inv_sub_bytes_ctrl: LANES=1 and LANES=4 instances fed by a GF(2^8)-derived
// inverse S-box model; directed scenarios plus randomized operations.
module tb_inv_sub_bytes_ctrl;

    localparam logic [127:0] T1V = {8'h04, 8'h46, 8'hdf, {13{8'h63}}};
    localparam logic [127:0] T1E = {8'h30, 8'h98, 8'hef, {13{8'h00}}};
    localparam logic [127:0] T2V = 128'h0;
    localparam logic [127:0] T2E = {16{8'h52}};

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start1 = 1'b0, start4 = 1'b0;
    logic [127:0]  din1 = '0, din4 = '0;
    logic          busy1, busy4, done1, done4;
    logic [127:0]  out1, out4;
    logic [7:0]    ss1, sr1;
    logic [31:0]   ss4, sr4;

    logic [7:0]    isb [256];
    logic          tbl_ready = 1'b0;
    int            n_tests = 0;
    int            n_fail  = 0;

    always #5 clk = ~clk;

    inv_sub_bytes_ctrl #(.LANES(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .state_in(din1), .busy(busy1), .done(done1),
        .state_out(out1), .sbox_state(ss1), .sbox_Sstate(sr1)
    );

    inv_sub_bytes_ctrl #(.LANES(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .state_in(din4), .busy(busy4), .done(done4),
        .state_out(out4), .sbox_state(ss4), .sbox_Sstate(sr4)
    );

    // Combinational Inv_Sbox lanes
    always_comb begin
        sr1 = tbl_ready ? isb[ss1] : 8'h00;
        sr4 = '0;
        for (int k = 0; k < 4; k++)
            sr4[8*k +: 8] = tbl_ready ? isb[ss4[8*k +: 8]] : 8'h00;
    end

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        a = a_in; b = b_in; p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    function automatic logic [7:0] byte_of(input logic [127:0] v, input int i);
        return v[8*(15 - i) +: 8];
    endfunction

    function automatic logic [127:0] inv_sub(input logic [127:0] v);
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) r[8*(15 - i) +: 8] = isb[byte_of(v, i)];
        return r;
    endfunction

    function automatic logic          get_busy(input bit s); return s ? busy4 : busy1; endfunction
    function automatic logic          get_done(input bit s); return s ? done4 : done1; endfunction
    function automatic logic [127:0]  get_out (input bit s); return s ? out4  : out1;  endfunction
    function automatic logic [31:0]   get_ss  (input bit s); return s ? ss4 : {24'h0, ss1}; endfunction

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic set_start(input bit s, input logic v, input logic [127:0] d);
        if (s) begin start4 = v; din4 = d; end
        else   begin start1 = v; din1 = d; end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // One operation; start re-pulsed on busy cycles p1/p2 with junk data must be ignored
    task automatic run_op(input bit s, input logic [127:0] din, input int p1, input int p2, input string tag);
        int           ng, lanes, c;
        logic [31:0]  el;
        logic [127:0] exp;
        ng    = s ? 4 : 16;
        lanes = s ? 4 : 1;
        exp   = inv_sub(din);
        set_start(s, 1'b1, din);
        step();
        set_start(s, 1'b0, rnd128());
        c = 0;
        while (get_busy(s) && c < 40) begin
            c++;
            check({tag, ".done_lo"}, 128'(get_done(s)), 128'(0));
            if (c <= ng) begin
                el = '0;
                for (int k = 0; k < lanes; k++) el[8*k +: 8] = byte_of(din, (c - 1) * lanes + k);
                check({tag, ".lanes"}, 128'(get_ss(s)), 128'(el));
            end
            if (c == p1 || c == p2) set_start(s, 1'b1, rnd128());
            else                    set_start(s, 1'b0, rnd128());
            step();
        end
        set_start(s, 1'b0, rnd128());
        check({tag, ".busy_cycles"}, 128'(c), 128'(ng));
        check({tag, ".done"}, 128'(get_done(s)), 128'(1));
        check({tag, ".out"}, get_out(s), exp);
        check({tag, ".lanes_idle"}, 128'(get_ss(s)), 128'(0));
        step();
        check({tag, ".done_pulse"}, 128'(get_done(s)), 128'(0));
        check({tag, ".busy_after"}, 128'(get_busy(s)), 128'(0));
        check({tag, ".out_held"}, get_out(s), exp);
    endtask

    initial begin
        logic [7:0]   inv, sv;
        logic [127:0] vec [2];
        logic [127:0] din;
        int           cnt, nd, ng, p1, p2;
        logic         saw_done;
        bit           s;

        // Inverse S-box from the forward definition: GF(2^8) inverse then affine map
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            if (x != 0)
                for (int y = 1; y < 256; y++)
                    if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sv = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
            isb[sv] = 8'(x);
        end
        tbl_ready = 1'b1;

        repeat (3) step();
        rst = 1'b0;
        check("reset.busy1", 128'(busy1), 128'(0));
        check("reset.done1", 128'(done1), 128'(0));
        check("reset.out1",  out1, 128'(0));
        check("reset.ss1",   128'(ss1), 128'(0));
        check("reset.out4",  out4, 128'(0));
        check("reset.busy4", 128'(busy4), 128'(0));

        // T1 and T2 with absolute expected values
        run_op(1'b0, T1V, -1, -1, "T1");
        check("T1.const", out1, T1E);
        run_op(1'b0, T2V, -1, -1, "T2");
        check("T2.const", out1, T2E);
        repeat (5) begin
            step();
            check("T2.stable", out1, T2E);
            check("T2.idle_lanes", 128'(ss1), 128'(0));
        end

        // T3: starts during busy are ignored
        run_op(1'b0, T1V, 3, 9, "T3");
        check("T3.const", out1, T1E);

        // T4: reset mid-run aborts without done
        set_start(1'b0, 1'b1, T1V);
        step();
        set_start(1'b0, 1'b0, T2V);
        repeat (6) step();
        check("T4.busy_pre", 128'(busy1), 128'(1));
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("T4.busy", 128'(busy1), 128'(0));
        check("T4.done", 128'(done1), 128'(0));
        check("T4.out",  out1, 128'(0));
        saw_done = 1'b0;
        repeat (25) begin
            step();
            if (done1 || busy1) saw_done = 1'b1;
        end
        check("T4.no_done", 128'(saw_done), 128'(0));
        run_op(1'b0, T2V, -1, -1, "T4.fresh");

        // T5: start held high, vectors alternating
        vec[0] = T1V;
        vec[1] = T2V;
        set_start(1'b0, 1'b1, vec[0]);
        step();
        cnt = 1;
        nd  = 0;
        while (nd < 4 && cnt < 60) begin
            if (done1) begin
                check("T5.period", 128'(cnt), 128'(17));
                check("T5.busy_lo", 128'(busy1), 128'(0));
                check("T5.out", out1, (nd % 2 == 0) ? T1E : T2E);
                nd++;
                if (nd < 4) set_start(1'b0, 1'b1, vec[nd % 2]);
                else        set_start(1'b0, 1'b0, T2V);
                cnt = 0;
            end
            step();
            cnt++;
        end
        check("T5.count", 128'(nd), 128'(4));
        repeat (3) step();
        check("T5.quiet", 128'(busy1), 128'(0));

        // T6: four lanes
        run_op(1'b1, T1V, -1, -1, "T6");
        check("T6.const", out4, T1E);
        run_op(1'b1, T2V, 2, 3, "T6.ign");
        check("T6.const2", out4, T2E);

        // Randomized operations on both widths
        for (int it = 0; it < 40; it++) begin
            s   = 1'($urandom_range(0, 1));
            ng  = s ? 4 : 16;
            din = rnd128();
            p1  = $urandom_range(0, 1) ? int'($urandom_range(1, ng)) : -1;
            p2  = $urandom_range(0, 1) ? int'($urandom_range(1, ng)) : -1;
            run_op(s, din, p1, p2, "rand");
            repeat ($urandom_range(0, 3)) begin
                step();
                check("rand.idle_lanes", 128'(get_ss(s)), 128'(0));
                check("rand.hold", get_out(s), inv_sub(din));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
